// File: rtl/psx_ddr_avalon_responder.sv
// Avalon-MM 64-bit burst responder backed by a word RAM, with programmable read latency.
// Optional waitrequest injection from an LFSR when WAIT_INJECT_EN is defined.
`timescale 1ns/1ps
module psx_ddr_avalon_responder #(
  parameter int MEM_AW       = 10,
  parameter int READ_LATENCY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [16:0] i_targetAddr,
  input  logic [2:0]  i_burstLength,
  input  logic        i_writeEnableMem,
  input  logic        i_readEnableMem,
  input  logic [63:0] i_dataMem,
  input  logic [7:0]  i_byteEnableMem,
  output logic        o_busyMem,
  output logic        o_dataValidMem,
  output logic [63:0] o_dataMem,
  output logic        o_protoErr
);

  typedef enum logic [1:0] {
    S_IDLE, S_WR_BURST, S_RD_WAIT, S_RD_DATA
  } state_t;

  state_t            r_state, w_next;
  logic              r_live;
  logic [MEM_AW-1:0] r_base;
  logic [2:0]        r_len, r_beat;
  logic [3:0]        r_lat;
  logic [63:0]       r_mem [2**MEM_AW];

  logic              w_stall, w_acc, w_lenOk;
  logic [2:0]        w_len;
  logic              w_idleWr, w_idleRd, w_burstWr;
  logic              w_wrEn, w_rdFire;
  logic [MEM_AW-1:0] w_wrAddr, w_offAddr;
  logic              w_unused_addr;

`ifdef WAIT_INJECT_EN
  logic [15:0] r_lfsr;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_lfsr <= 16'hACE1;
    else r_lfsr <= {r_lfsr[14:0],
                    r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
  end
  assign w_stall = r_lfsr[0] | r_lfsr[3];
`else
  assign w_stall = 1'b0;
`endif

  assign w_unused_addr = ^i_targetAddr[16:MEM_AW];

  // Only IDLE and WR_BURST ever take requests.
  assign o_busyMem = !(r_live && !w_stall &&
                       (r_state == S_IDLE || r_state == S_WR_BURST));

  assign w_acc     = (i_writeEnableMem | i_readEnableMem) & ~o_busyMem;
  assign w_lenOk   = (i_burstLength != 3'd0) && (i_burstLength <= 3'd4);
  assign w_len     = w_lenOk ? i_burstLength : 3'd1;
  assign w_idleWr  = (r_state == S_IDLE) && w_acc && i_writeEnableMem;
  assign w_idleRd  = (r_state == S_IDLE) && w_acc && !i_writeEnableMem;
  assign w_burstWr = (r_state == S_WR_BURST) && i_writeEnableMem && !o_busyMem;
  assign w_wrEn    = w_idleWr | w_burstWr;
  assign w_offAddr = r_base + MEM_AW'(r_beat);
  assign w_wrAddr  = (r_state == S_IDLE) ? i_targetAddr[MEM_AW-1:0] : w_offAddr;
  assign w_rdFire  = ((r_state == S_RD_WAIT) && (r_lat == 4'd0)) ||
                     ((r_state == S_RD_DATA) && (r_beat != r_len));

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_idleWr && w_len != 3'd1) w_next = S_WR_BURST;
        else if (w_idleRd) w_next = S_RD_WAIT;
      end
      S_WR_BURST: if (w_burstWr && r_beat == r_len - 3'd1) w_next = S_IDLE;
      S_RD_WAIT:  if (r_lat == 4'd0) w_next = S_RD_DATA;
      S_RD_DATA:  if (r_beat == r_len) w_next = S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state        <= S_IDLE;
      r_live         <= 1'b0;
      r_base         <= '0;
      r_len          <= 3'd0;
      r_beat         <= 3'd0;
      r_lat          <= 4'd0;
      o_dataValidMem <= 1'b0;
      o_dataMem      <= 64'd0;
      o_protoErr     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_live  <= 1'b1;
      if (w_idleWr || w_idleRd) begin
        r_base <= i_targetAddr[MEM_AW-1:0];
        r_len  <= w_len;
        r_beat <= w_idleWr ? 3'd1 : 3'd0;
        r_lat  <= 4'(READ_LATENCY - 1);
      end else if (w_burstWr || w_rdFire) begin
        r_beat <= r_beat + 3'd1;
      end
      if (r_state == S_RD_WAIT && r_lat != 4'd0) r_lat <= r_lat - 4'd1;
      // RAM is read one cycle ahead so the data lands registered with valid.
      o_dataValidMem <= w_rdFire;
      if (w_rdFire) o_dataMem <= r_mem[w_offAddr];
      if ((r_state == S_IDLE && w_acc &&
           (!w_lenOk || (i_writeEnableMem && i_readEnableMem))) ||
          (r_state == S_WR_BURST && i_readEnableMem))
        o_protoErr <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wrEn)
      for (int b = 0; b < 8; b++)
        if (i_byteEnableMem[b]) r_mem[w_wrAddr][b*8 +: 8] <= i_dataMem[b*8 +: 8];
  end

endmodule

// File: tb/tb_psx_ddr_avalon_responder.sv
// Scoreboard bench for psx_ddr_avalon_responder against a flat word-array memory model.
`timescale 1ns/1ps
module tb_psx_ddr_avalon_responder;
  localparam int RL = 2;
  localparam int AW = 10;
  localparam int D  = 1 << AW;

  logic        clk = 1'b0, rst = 1'b1;
  logic [16:0] i_targetAddr;
  logic [2:0]  i_burstLength;
  logic        i_writeEnableMem, i_readEnableMem;
  logic [63:0] i_dataMem;
  logic [7:0]  i_byteEnableMem;
  logic        o_busyMem, o_dataValidMem, o_protoErr;
  logic [63:0] o_dataMem;

  always #5 clk = ~clk;

  psx_ddr_avalon_responder #(.MEM_AW(AW), .READ_LATENCY(RL)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_targetAddr(i_targetAddr), .i_burstLength(i_burstLength),
    .i_writeEnableMem(i_writeEnableMem), .i_readEnableMem(i_readEnableMem),
    .i_dataMem(i_dataMem), .i_byteEnableMem(i_byteEnableMem),
    .o_busyMem(o_busyMem), .o_dataValidMem(o_dataValidMem),
    .o_dataMem(o_dataMem), .o_protoErr(o_protoErr)
  );

  typedef struct { logic [63:0] d; int c; bit last; } exp_t;
  exp_t q[$];

  int tests = 0, fails = 0, cyc = 0;
  bit mon_off = 0, busy_chk = 0, use_x = 0;
  logic [63:0] mdl [D];
  logic [63:0] wd [4];
  logic [63:0] xd [4];
  logic [7:0]  wbe [4];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h t=%0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (busy_chk) begin
      busy_chk = 0;
`ifndef WAIT_INJECT_EN
      check("busy_after_burst", {63'd0, o_busyMem}, 64'd0);
`endif
    end
    if (o_dataValidMem && !mon_off) begin
      if (q.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_valid actual=1 expected=0 t=%0t", $time);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rd_data", o_dataMem, e.d);
        check("rd_cycle", 64'(cyc), 64'(e.c));
        if (e.last) busy_chk = 1;
      end
    end
  end

  task automatic wait_accept(output bit ok);
    ok = 0;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      if (!o_busyMem) begin ok = 1; return; end
    end
    tests++; fails++;
    $display("FAIL accept_timeout actual=busy expected=accept t=%0t", $time);
  endtask

  function automatic int eff_len(input logic [2:0] bl);
    return (bl >= 3'd1 && bl <= 3'd4) ? int'(bl) : 1;
  endfunction

  task automatic wr(input logic [16:0] a, input logic [2:0] bl, input bit gaps);
    int n;
    bit ok;
    n = eff_len(bl);
    for (int k = 0; k < n; k++) begin
      i_writeEnableMem = 1;
      i_targetAddr  = (k == 0) ? a : 17'($urandom);
      i_burstLength = (k == 0) ? bl : 3'($urandom);
      i_dataMem       = wd[k];
      i_byteEnableMem = wbe[k];
      wait_accept(ok);
      if (ok)
        for (int b = 0; b < 8; b++)
          if (wbe[k][b]) mdl[(int'(a) + k) % D][b*8 +: 8] = wd[k][b*8 +: 8];
      @(posedge clk); #1;
      i_writeEnableMem = 0;
      if (!ok) return;
      if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic rd(input logic [16:0] a, input logic [2:0] bl);
    int n, t;
    bit ok;
    exp_t e;
    n = eff_len(bl);
    i_readEnableMem = 1;
    i_targetAddr    = a;
    i_burstLength   = bl;
    wait_accept(ok);
    if (ok)
      for (int k = 0; k < n; k++) begin
        e.d = use_x ? xd[k] : mdl[(int'(a) + k) % D];
        e.c = cyc + 1 + RL + k;
        e.last = (k == n - 1);
        q.push_back(e);
      end
    @(posedge clk); #1;
    i_readEnableMem = 0;
    if (!ok) return;
    t = 0;
    while (q.size() != 0 && t < 100) begin @(posedge clk); #1; t++; end
    if (q.size() != 0) begin
      tests++; fails++;
      $display("FAIL rd_timeout actual=%0d_pending expected=0 t=%0t", q.size(), $time);
      q.delete();
    end
  endtask

  initial begin
    #5ms;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    bit ok;
    int t;
    i_targetAddr = 0; i_burstLength = 1; i_dataMem = 0; i_byteEnableMem = 0;
    i_writeEnableMem = 0; i_readEnableMem = 0;
    repeat (3) @(negedge clk);
    check("rst_busy", {63'd0, o_busyMem}, 64'd1);
    check("rst_valid", {63'd0, o_dataValidMem}, 64'd0);
    check("rst_data", o_dataMem, 64'd0);
    check("rst_perr", {63'd0, o_protoErr}, 64'd0);
    rst = 0;
    @(posedge clk); @(negedge clk);
`ifndef WAIT_INJECT_EN
    check("busy_after_rel", {63'd0, o_busyMem}, 64'd0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < D / 4; i++) begin
      for (int k = 0; k < 4; k++) begin
        wd[k] = {$urandom, $urandom}; wbe[k] = 8'hFF;
      end
      wr(17'(i * 4), 3'd4, 0);
    end

    wd[0] = 64'h1111111111111111; wd[1] = 64'h2222222222222222;
    wd[2] = 64'h3333333333333333; wd[3] = 64'h4444444444444444;
    for (int k = 0; k < 4; k++) begin wbe[k] = 8'hFF; xd[k] = wd[k]; end
    wr(17'h00010, 3'd4, 0);
    use_x = 1; rd(17'h00010, 3'd4); use_x = 0;

    wd[0] = 64'hFFFFFFFFFFFFFFFF; wbe[0] = 8'hFF;
    wr(17'h00020, 3'd1, 0);
    wd[0] = 64'h0123456789ABCDEF; wbe[0] = 8'h0F;
    wr(17'h00020, 3'd1, 0);
    xd[0] = 64'hFFFFFFFF89ABCDEF;
    use_x = 1; rd(17'h00020, 3'd1); use_x = 0;

    for (int k = 0; k < 4; k++) begin wd[k] = {$urandom, $urandom}; wbe[k] = 8'hFF; end
    wr(17'h003FE, 3'd4, 1);
    rd(17'h003FE, 3'd4);
    rd(17'h00400, 3'd1);
    rd(17'h1FFFF, 3'd2);
    check("perr_clean", {63'd0, o_protoErr}, 64'd0);

    // write and read together: write wins, read dropped
    i_writeEnableMem = 1; i_readEnableMem = 1;
    i_targetAddr = 17'h00050; i_burstLength = 3'd1;
    i_dataMem = {$urandom, $urandom}; i_byteEnableMem = 8'hFF;
    wait_accept(ok);
    if (ok) mdl[16'h50] = i_dataMem;
    @(posedge clk); #1;
    i_writeEnableMem = 0; i_readEnableMem = 0;
    repeat (6) begin @(posedge clk); #1; end
    check("perr_both", {63'd0, o_protoErr}, 64'd1);
    rd(17'h00050, 3'd1);
    check("perr_sticky", {63'd0, o_protoErr}, 64'd1);

    // reset in the middle of a read burst
    mon_off = 1;
    i_readEnableMem = 1; i_targetAddr = 17'h00010; i_burstLength = 3'd4;
    wait_accept(ok);
    @(posedge clk); #1;
    i_readEnableMem = 0;
    t = 0;
    while (!o_dataValidMem && t < 50) begin @(posedge clk); #1; t++; end
    check("midrst_beat1_valid", {63'd0, o_dataValidMem}, 64'd1);
    check("midrst_beat1_data", o_dataMem, mdl[16]);
    #2 rst = 1;
    #1;
    check("midrst_valid", {63'd0, o_dataValidMem}, 64'd0);
    check("midrst_busy", {63'd0, o_busyMem}, 64'd1);
    @(negedge clk);
    check("midrst_busy_hold", {63'd0, o_busyMem}, 64'd1);
    rst = 0;
    @(posedge clk); @(negedge clk);
`ifndef WAIT_INJECT_EN
    check("midrst_busy_rel", {63'd0, o_busyMem}, 64'd0);
`endif
    check("midrst_valid_rel", {63'd0, o_dataValidMem}, 64'd0);
    check("midrst_perr", {63'd0, o_protoErr}, 64'd0);
    mon_off = 0;
    @(posedge clk); #1;
    repeat (8) begin @(posedge clk); #1; end

    // illegal burst lengths behave as a single beat
    wd[0] = {$urandom, $urandom}; wbe[0] = 8'hFF;
    wd[1] = {$urandom, $urandom}; wbe[1] = 8'hFF;
    wr(17'h00060, 3'd5, 0);
    check("perr_len5", {63'd0, o_protoErr}, 64'd1);
    rd(17'h00060, 3'd2);
    rd(17'h00064, 3'd0);

    for (int i = 0; i < 100; i++) begin
      logic [16:0] a;
      logic [2:0]  bl;
      a  = 17'($urandom);
      bl = 3'($urandom_range(1, 4));
      for (int k = 0; k < 4; k++) begin
        wd[k]  = {$urandom, $urandom};
        wbe[k] = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      end
      wr(a, bl, 1);
      rd(a, bl);
      if ($urandom_range(0, 3) == 0) rd(17'($urandom), 3'($urandom_range(1, 4)));
    end

    repeat (4) begin @(posedge clk); #1; end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
